flag_branch_sequencer: RTL and testbench

Program-counter sequencer that consumes the registered carry (C) and zero (Z) flags produced by the ALU status register and decides the next instruction address. It executes one control operation per enabled cycle: sequential step, unconditional jump, flag-conditional jumps, and call/return through a small internal return stack. It sits between the ALU datapath and instruction memory, closing the loop from ALU flags back to fetch.

---
 rtl/flag_branch_sequencer_pkg.sv | 23 ++
 rtl/flag_branch_sequencer_return_stack.sv | 60 ++++++
 rtl/flag_branch_sequencer.sv | 122 ++++++++++++
 tb/tb_flag_branch_sequencer.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/flag_branch_sequencer_pkg.sv
// Shared definitions for the flag-driven branch sequencer: opcodes, FSM states
// and the default address width.
package flag_branch_sequencer_pkg;

  localparam int DEFAULT_PC_WIDTH = 4;

  typedef enum logic [2:0] {
    OP_NEXT = 3'b000,
    OP_JMP  = 3'b001,
    OP_JC   = 3'b010,
    OP_JNC  = 3'b011,
    OP_JZ   = 3'b100,
    OP_JNZ  = 3'b101,
    OP_CALL = 3'b110,
    OP_RET  = 3'b111
  } op_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

endpackage

// File: rtl/flag_branch_sequencer_return_stack.sv
// LIFO return-address stack with combinational top-of-stack output.
// Push while full and pop while empty are ignored; the caller detects them.
module flag_branch_sequencer_return_stack
  import flag_branch_sequencer_pkg::*;
#(
  parameter int PC_WIDTH    = DEFAULT_PC_WIDTH,
  parameter int STACK_DEPTH = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                PUSH,
  input  logic                POP,
  input  logic [PC_WIDTH-1:0] DIN,
  output logic [PC_WIDTH-1:0] DOUT,
  output logic                FULL,
  output logic                EMPTY
);

  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = IDX_W + 1;

  logic [PC_WIDTH-1:0] mem_q [STACK_DEPTH];
  logic [SP_W-1:0]     sp_q, sp_d;
  logic [IDX_W-1:0]    wr_idx_s, top_idx_s;
  logic                do_push_s;

  // The write slot is SP itself; when full its low bits wrap to 0, so SP-1 still names the top.
  assign wr_idx_s  = sp_q[IDX_W-1:0];
  assign top_idx_s = wr_idx_s - IDX_W'(1);
  assign FULL      = (sp_q == SP_W'(STACK_DEPTH));
  assign EMPTY     = (sp_q == SP_W'(0));
  assign DOUT      = EMPTY ? {PC_WIDTH{1'b0}} : mem_q[top_idx_s];
  assign do_push_s = PUSH && !FULL;

  always_comb begin
    sp_d = sp_q;
    if (do_push_s) begin
      sp_d = sp_q + SP_W'(1);
    end else if (POP && !EMPTY) begin
      sp_d = sp_q - SP_W'(1);
    end else begin
      sp_d = sp_q;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sp_q <= SP_W'(0);
      for (int i = 0; i < STACK_DEPTH; i++) begin
        mem_q[i] <= {PC_WIDTH{1'b0}};
      end
    end else begin
      sp_q <= sp_d;
      if (do_push_s) begin
        mem_q[wr_idx_s] <= DIN;
      end
    end
  end

endmodule

// File: rtl/flag_branch_sequencer.sv
// Program-counter sequencer: picks the next fetch address from the opcode and the
// registered ALU C/Z flags, with call/return through a small return stack.
module flag_branch_sequencer
  import flag_branch_sequencer_pkg::*;
#(
  parameter int PC_WIDTH    = DEFAULT_PC_WIDTH,
  parameter int STACK_DEPTH = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                EN,
  input  logic [2:0]          OP,
  input  logic [PC_WIDTH-1:0] IMM,
  input  logic                C,
  input  logic                Z,
  output logic [PC_WIDTH-1:0] PC,
  output logic                TAKEN,
  output logic                HALTED,
  output logic                ERR
);

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d, pc_inc_s;
  logic                taken_q, taken_d;
  logic                err_q, err_d;
  logic                push_s, pop_s;
  logic [PC_WIDTH-1:0] stk_top_s;
  logic                stk_full_s, stk_empty_s;

  flag_branch_sequencer_return_stack #(
    .PC_WIDTH   (PC_WIDTH),
    .STACK_DEPTH(STACK_DEPTH)
  ) u_stack (
    .CLK  (CLK),
    .RST  (RST),
    .PUSH (push_s),
    .POP  (pop_s),
    .DIN  (pc_inc_s),
    .DOUT (stk_top_s),
    .FULL (stk_full_s),
    .EMPTY(stk_empty_s)
  );

  assign pc_inc_s = pc_q + PC_WIDTH'(1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    taken_d = 1'b0;
    err_d   = err_q;
    push_s  = 1'b0;
    pop_s   = 1'b0;
    if (state_q == ST_RUN && EN) begin
      case (OP)
        OP_NEXT: pc_d = pc_inc_s;
        OP_JMP: begin
          pc_d    = IMM;
          taken_d = 1'b1;
        end
        OP_JC: begin
          pc_d    = C ? IMM : pc_inc_s;
          taken_d = C;
        end
        OP_JNC: begin
          pc_d    = !C ? IMM : pc_inc_s;
          taken_d = !C;
        end
        OP_JZ: begin
          pc_d    = Z ? IMM : pc_inc_s;
          taken_d = Z;
        end
        OP_JNZ: begin
          pc_d    = !Z ? IMM : pc_inc_s;
          taken_d = !Z;
        end
        OP_CALL: begin
          if (stk_full_s) begin
            state_d = ST_HALT;
            err_d   = 1'b1;
          end else begin
            push_s  = 1'b1;
            pc_d    = IMM;
            taken_d = 1'b1;
          end
        end
        OP_RET: begin
          if (stk_empty_s) begin
            state_d = ST_HALT;
            err_d   = 1'b1;
          end else begin
            pop_s   = 1'b1;
            pc_d    = stk_top_s;
            taken_d = 1'b1;
          end
        end
        default: pc_d = pc_q;
      endcase
    end else begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_RUN;
      pc_q    <= {PC_WIDTH{1'b0}};
      taken_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      taken_q <= taken_d;
      err_q   <= err_d;
    end
  end

  assign PC     = pc_q;
  assign TAKEN  = taken_q;
  assign HALTED = (state_q == ST_HALT);
  assign ERR    = err_q;

endmodule

// File: tb/tb_flag_branch_sequencer.sv
// Directed plus random test of flag_branch_sequencer against a queue-based reference model.
module tb_flag_branch_sequencer;

  localparam int PW    = 4;
  localparam int DEPTH = 4;
  localparam int MODV  = 1 << PW;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          EN  = 1'b0;
  logic [2:0]    OP  = 3'd0;
  logic [PW-1:0] IMM = '0;
  logic          C   = 1'b0;
  logic          Z   = 1'b0;
  logic [PW-1:0] PC;
  logic          TAKEN, HALTED, ERR;

  int total = 0;
  int bad   = 0;

  int m_pc;
  bit m_taken, m_halt, m_err;
  int m_stk[$];

  flag_branch_sequencer #(.PC_WIDTH(PW), .STACK_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .OP(OP), .IMM(IMM), .C(C), .Z(Z),
    .PC(PC), .TAKEN(TAKEN), .HALTED(HALTED), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_pc"}, int'(PC), m_pc);
    chk({tag, "_taken"}, int'(TAKEN), int'(m_taken));
    chk({tag, "_halted"}, int'(HALTED), int'(m_halt));
    chk({tag, "_err"}, int'(ERR), int'(m_err));
  endtask

  task automatic model_step(input bit en, input int o, input int imm, input bit c, input bit z);
    int nxt;
    nxt     = (m_pc + 1) % MODV;
    m_taken = 1'b0;
    if (!m_halt && en) begin
      case (o)
        0: m_pc = nxt;
        1: begin m_pc = imm; m_taken = 1'b1; end
        2: begin m_pc = c  ? imm : nxt; m_taken = c;  end
        3: begin m_pc = !c ? imm : nxt; m_taken = !c; end
        4: begin m_pc = z  ? imm : nxt; m_taken = z;  end
        5: begin m_pc = !z ? imm : nxt; m_taken = !z; end
        6: begin
          if (m_stk.size() == DEPTH) begin
            m_halt = 1'b1; m_err = 1'b1;
          end else begin
            m_stk.push_back(nxt); m_pc = imm; m_taken = 1'b1;
          end
        end
        default: begin
          if (m_stk.size() == 0) begin
            m_halt = 1'b1; m_err = 1'b1;
          end else begin
            m_pc = m_stk.pop_back(); m_taken = 1'b1;
          end
        end
      endcase
    end
  endtask

  task automatic step(input bit en, input int o, input int imm, input bit c, input bit z,
                      input string tag);
    EN  = en;
    OP  = 3'(o);
    IMM = PW'(imm);
    C   = c;
    Z   = z;
    @(posedge CLK);
    #1;
    model_step(en, o, imm, c, z);
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    RST = 1'b1;
    #2;
    m_pc = 0; m_taken = 1'b0; m_halt = 1'b0; m_err = 1'b0;
    m_stk.delete();
    check_all(tag);
    RST = 1'b0;
  endtask

  initial begin
    @(posedge CLK);
    #1;
    do_reset("reset");

    for (int i = 0; i < 17; i++) step(1'b1, 0, 0, 1'b0, 1'b0, "next");
    chk("wrap_pc", int'(PC), 1);

    step(1'b1, 2, 9, 1'b1, 1'b0, "jc");
    chk("jc_lit", int'(PC), 9);
    step(1'b1, 4, 3, 1'b1, 1'b0, "jz_untaken");
    chk("jz_lit", int'(PC), 10);
    step(1'b1, 5, 3, 1'b1, 1'b0, "jnz");
    chk("jnz_lit", int'(PC), 3);
    step(1'b1, 3, 12, 1'b1, 1'b0, "jnc_untaken");

    for (int i = 0; i < 3; i++) step(1'b0, 1, 7, 1'b0, 1'b0, "en_low");
    step(1'b1, 1, 7, 1'b0, 1'b0, "jmp");
    chk("jmp_lit", int'(PC), 7);

    step(1'b1, 1, 2, 1'b0, 1'b0, "jmp2");
    step(1'b1, 6, 5, 1'b0, 1'b0, "call5");
    step(1'b1, 6, 8, 1'b0, 1'b0, "call8");
    step(1'b1, 7, 0, 1'b0, 1'b0, "ret1");
    chk("ret1_lit", int'(PC), 6);
    step(1'b1, 7, 0, 1'b0, 1'b0, "ret2");
    chk("ret2_lit", int'(PC), 3);

    step(1'b1, 1, 0, 1'b0, 1'b0, "jmp0");
    for (int i = 0; i < 4; i++) step(1'b1, 6, 1, 1'b0, 1'b0, "call_fill");
    step(1'b1, 6, 12, 1'b0, 1'b0, "call_ovf");
    chk("ovf_halt_lit", int'(HALTED), 1);
    chk("ovf_pc_lit", int'(PC), 1);
    step(1'b1, 1, 4, 1'b0, 1'b0, "halt_jmp");

    do_reset("reset2");
    step(1'b1, 7, 0, 1'b0, 1'b0, "ret_udf");
    chk("udf_err_lit", int'(ERR), 1);
    step(1'b1, 0, 0, 1'b0, 1'b0, "halt_next");
    do_reset("reset_halt");
    step(1'b1, 0, 0, 1'b0, 1'b0, "after_rst");
    chk("after_rst_lit", int'(PC), 1);

    // CALL at PC=15 must push the wrapped address 0
    step(1'b1, 1, 15, 1'b0, 1'b0, "jmp15");
    step(1'b1, 6, 6, 1'b0, 1'b0, "call_at15");
    step(1'b1, 7, 0, 1'b0, 1'b0, "ret_wrap");
    chk("ret_wrap_lit", int'(PC), 0);

    for (int i = 0; i < 600; i++) begin
      if (m_halt && ($urandom_range(0, 3) == 0)) begin
        do_reset("rnd_reset");
      end else begin
        step(($urandom_range(0, 4) != 0), int'($urandom_range(0, 7)),
             int'($urandom_range(0, MODV - 1)), 1'($urandom), 1'($urandom), "rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
